// File: rtl/spart_responder.sv
// ---------------------------------------------------------------------------
// spart_responder
//
// Peripheral end of the SPART processor bus. It decodes bus accesses, holds
// the 16-bit baud divisor (DBH:DBL), and generates a 16x-oversampled baud
// enable. It also serialises TX bytes and deserialises RX bytes as 8N1,
// LSB first.
//
// Ports
//   clk      in     system clock
//   rst      in     asynchronous active-high reset
//   iocs     in     chip select; an access is valid only while high
//   iorw     in     1 = read (this block drives databus), 0 = write
//   ioaddr   in     00 TX/RX buffer, 01 status, 10 DBL, 11 DBH
//   databus  inout  8-bit bidirectional data, released (z) when not read
//   rda      out    receive data available
//   tbr      out    transmit buffer ready (TX buffer empty)
//   txd      out    serial out, idle high
//   rxd      in     serial in, asynchronous to clk
//
// Configuration macro
//   SPART_OVERRUN_EN  when defined, builds the overrun flag (status bit 2).
//                     Otherwise that bit reads 0 and no flop exists.
// ---------------------------------------------------------------------------
module spart_responder #(
    parameter logic [15:0] DIV_RESET = 16'h0516
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  logic [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [7:0]  dbl, dbh, tx_buf, rx_buf, rd_data;
    logic [15:0] baud_cnt;
    logic        reload_pending, baud_en, ovr;

    logic rd_acc, wr_acc, wr_tx, wr_dbl, wr_dbh, rd_rx, rd_status;

    assign rd_acc    = iocs & iorw;
    assign wr_acc    = iocs & ~iorw;
    assign wr_tx     = wr_acc && (ioaddr == 2'b00) && tbr;
    assign wr_dbl    = wr_acc && (ioaddr == 2'b10);
    assign wr_dbh    = wr_acc && (ioaddr == 2'b11);
    assign rd_rx     = rd_acc && (ioaddr == 2'b00);
    assign rd_status = rd_acc && (ioaddr == 2'b01);

    // Read data is purely combinational so the processor sees it within the access cycle.
    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            2'b00: rd_data = rx_buf;
            2'b01: rd_data = {5'b0, ovr, rda, tbr};
            2'b10: rd_data = dbl;
            2'b11: rd_data = dbh;
            default: rd_data = 8'h00;
        endcase
    end

    assign databus = rd_acc ? rd_data : 8'hzz;

    // A divisor write takes effect one cycle later, once the new byte is in its register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbl            <= DIV_RESET[7:0];
            dbh            <= DIV_RESET[15:8];
            reload_pending <= 1'b0;
        end else begin
            reload_pending <= wr_dbl | wr_dbh;
            if (wr_dbl) dbl <= databus;
            if (wr_dbh) dbh <= databus;
        end
    end

    // The enable fires every divisor+1 cycles, so a divisor of 0 gives an enable on every cycle.
    assign baud_en = (baud_cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          baud_cnt <= 16'd0;
        else if (reload_pending || baud_en) baud_cnt <= {dbh, dbl};
        else                              baud_cnt <= baud_cnt - 16'd1;
    end

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_state_nxt;
    logic [3:0] tx_tick, tx_tick_nxt;
    logic [2:0] tx_bit, tx_bit_nxt;
    logic [7:0] tx_shift, tx_shift_nxt;
    logic       txd_nxt, tx_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tick  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_tick  <= tx_tick_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            txd      <= txd_nxt;
        end
    end

    // Each bit changes txd on the first of its 16 enables. The end of a stop bit may chain
    // straight into the next start bit when a byte is already waiting.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_tick_nxt  = tx_tick;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        txd_nxt      = txd;
        tx_load      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tbr) tx_load = 1'b1;
            end
            TX_START: begin
                if (baud_en) begin
                    if (tx_tick == 4'd0) txd_nxt = 1'b0;
                    tx_tick_nxt = tx_tick + 4'd1;
                    if (tx_tick == 4'd15) begin
                        tx_state_nxt = TX_DATA;
                        tx_bit_nxt   = 3'd0;
                    end
                end
            end
            TX_DATA: begin
                if (baud_en) begin
                    if (tx_tick == 4'd0) txd_nxt = tx_shift[0];
                    tx_tick_nxt = tx_tick + 4'd1;
                    if (tx_tick == 4'd15) begin
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_bit_nxt   = tx_bit + 3'd1;
                        if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (baud_en) begin
                    if (tx_tick == 4'd0) txd_nxt = 1'b1;
                    tx_tick_nxt = tx_tick + 4'd1;
                    if (tx_tick == 4'd15) begin
                        if (!tbr) tx_load = 1'b1;
                        else      tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_state_nxt = TX_START;
            tx_shift_nxt = tx_buf;
            tx_tick_nxt  = 4'd0;
        end
    end

    // A bus write only lands when the buffer is empty, and the shifter only takes a byte when it
    // is full, so these two events can never occur on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf <= 8'h00;
            tbr    <= 1'b1;
        end else if (wr_tx) begin
            tx_buf <= databus;
            tbr    <= 1'b0;
        end else if (tx_load) begin
            tbr    <= 1'b1;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t  rx_state, rx_state_nxt;
    logic [3:0] rx_tick, rx_tick_nxt;
    logic [2:0] rx_bit, rx_bit_nxt;
    logic [7:0] rx_shift, rx_shift_nxt;
    logic       rx_sync1, rx_sync2, rx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tick  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_sync1 <= rxd;
            rx_sync2 <= rx_sync1;
            rx_state <= rx_state_nxt;
            rx_tick  <= rx_tick_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    // Resampling 8 enables into the start bit puts every later sample at mid-bit. A start bit
    // that is high again at that point is treated as a glitch.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_tick_nxt  = rx_tick;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync2) begin
                    rx_state_nxt = RX_START;
                    rx_tick_nxt  = 4'd0;
                end
            end
            RX_START: begin
                if (baud_en) begin
                    if (rx_tick == 4'd7) begin
                        rx_tick_nxt  = 4'd0;
                        rx_bit_nxt   = 3'd0;
                        rx_state_nxt = rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_nxt = rx_tick + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (baud_en) begin
                    rx_tick_nxt = rx_tick + 4'd1;
                    if (rx_tick == 4'd15) begin
                        rx_shift_nxt = {rx_sync2, rx_shift[7:1]};
                        rx_bit_nxt   = rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_en) begin
                    rx_tick_nxt = rx_tick + 4'd1;
                    if (rx_tick == 4'd15) begin
                        rx_state_nxt = RX_IDLE;
                        rx_done      = rx_sync2;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // A completing byte takes priority over a buffer read that would clear rda.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf <= 8'h00;
            rda    <= 1'b0;
        end else if (rx_done) begin
            rx_buf <= rx_shift;
            rda    <= 1'b1;
        end else if (rd_rx) begin
            rda    <= 1'b0;
        end
    end

`ifdef SPART_OVERRUN_EN
    // Overrun records that an unread byte was overwritten. Setting it wins over a status-read clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 ovr <= 1'b0;
        else if (rx_done && rda) ovr <= 1'b1;
        else if (rd_status)      ovr <= 1'b0;
    end
`else
    assign ovr = 1'b0;
    logic unused_rd_status;
    assign unused_rd_status = rd_status;
`endif

endmodule

// File: tb/tb_spart_responder.sv
// ---------------------------------------------------------------------------
// tb_spart_responder
//
// Self-checking bench for spart_responder. A frame-level model is kept here:
// a queue of bytes that must appear on txd, plus the rda/ovr/RX-buffer state
// implied by the frames the bench sends and the reads it issues. One compare
// process checks txd at every mid-bit (and idle-high otherwise) and rda on
// every cycle when no RX frame is in flight.
// ---------------------------------------------------------------------------
module tb_spart_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs, iorw, rxd;
    logic [1:0] ioaddr;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    wire  [7:0] databus;
    logic       rda, tbr, txd;

    assign databus = tb_drv ? tb_wdata : 8'hzz;

    spart_responder dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state
    int         b_clk;
    logic [7:0] txq[$];
    bit         tx_in;
    int         tx_cyc, tx_wait, tx_idx;
    logic [9:0] tx_bits;
    logic [7:0] tx_next;
    bit         chk_en, rx_busy;
    logic       m_rda, m_ovr;
    logic [7:0] m_rxbuf;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", name, act, want, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    // Continuous comparison: txd against the expected frame bits, rda against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rx_busy) checkOutput("rda", {7'b0, rda}, {7'b0, m_rda});
            if (!tx_in) begin
                if (txq.size() == 0) begin
                    checkOutput("txd_idle", {7'b0, txd}, 8'h01);
                end else if (txd == 1'b0) begin
                    tx_next = txq.pop_front();
                    tx_bits = {1'b1, tx_next, 1'b0};
                    tx_in   = 1'b1;
                    tx_cyc  = 0;
                    tx_wait = 0;
                end else begin
                    tx_wait++;
                    if (tx_wait > 4 * b_clk) begin
                        reportTimeout("tx_start");
                        tx_next = txq.pop_front();
                        tx_wait = 0;
                    end
                end
            end else begin
                tx_cyc++;
                if (tx_cyc >= 0 && (tx_cyc % b_clk) == b_clk / 2) begin
                    tx_idx = tx_cyc / b_clk;
                    checkOutput("txd_bit", {7'b0, txd}, {7'b0, tx_bits[tx_idx]});
                    if (tx_idx == 9) begin
                        if (txq.size() != 0) begin
                            // A waiting byte must follow the stop bit with no idle gap.
                            tx_next = txq.pop_front();
                            tx_bits = {1'b1, tx_next, 1'b0};
                            tx_cyc  = tx_cyc - 10 * b_clk;
                        end else begin
                            tx_in = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Bus write: one-cycle access sampled on the second rising edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b0; ioaddr = addr; tb_wdata = data; tb_drv = 1'b1;
        @(posedge clk); #1;
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [7:0] data);
        @(posedge clk); #1;
        iocs = 1'b1; iorw = 1'b1; ioaddr = addr;
        @(negedge clk);
        data = databus;
        @(posedge clk); #1;
        iocs = 1'b0;
    endtask

    task automatic setDivisor(input logic [15:0] d);
        logic [7:0] rd;
        applyStimulus(2'b10, d[7:0]);
        applyStimulus(2'b11, d[15:8]);
        b_clk = 16 * (int'(d) + 1);
        repeat (4) @(posedge clk);
        busRead(2'b10, rd);
        checkOutput("dbl_readback", rd, d[7:0]);
        busRead(2'b11, rd);
        checkOutput("dbh_readback", rd, d[15:8]);
    endtask

    task automatic waitTxDone();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 * b_clk; i++) begin
            @(posedge clk);
            if (txq.size() == 0 && !tx_in) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) reportTimeout("tx_done");
        repeat (b_clk) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame on rxd. A bad stop bit is held low for only 3/4 of a bit so
    // the receiver's restart after the stop sample is rejected as a glitch.
    task automatic sendRxFrame(input logic [7:0] data, input bit stop_ok);
        logic [8:0] bits;
        bits = {data, 1'b0};
        rx_busy = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            rxd = bits[i];
            repeat (b_clk) @(posedge clk);
            #1;
        end
        if (stop_ok) begin
            rxd = 1'b1;
            repeat (b_clk) @(posedge clk);
            #1;
`ifdef SPART_OVERRUN_EN
            if (m_rda) m_ovr = 1'b1;
`endif
            m_rda   = 1'b1;
            m_rxbuf = data;
        end else begin
            rxd = 1'b0;
            repeat (3 * b_clk / 4) @(posedge clk);
            #1;
            rxd = 1'b1;
            repeat (b_clk / 4) @(posedge clk);
            #1;
        end
        rx_busy = 1'b0;
        repeat (2 * b_clk) @(posedge clk);
        #1;
    endtask

    task automatic readRx();
        logic [7:0] rd;
        busRead(2'b00, rd);
        checkOutput("rx_data", rd, m_rxbuf);
        m_rda = 1'b0;
    endtask

    task automatic readStatus();
        logic [7:0] rd;
        busRead(2'b01, rd);
        checkOutput("status", rd, {5'b0, m_ovr, m_rda, 1'b1});
        m_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0]  rd;
        logic [15:0] div;
        logic [7:0]  byte_v;
        int          cnt;
        bit          seen;

        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        tb_drv = 1'b0; tb_wdata = 8'h00; rxd = 1'b1;
        chk_en = 1'b0; rx_busy = 1'b0; tx_in = 1'b0;
        tx_cyc = 0; tx_wait = 0; tx_idx = 0;
        m_rda = 1'b0; m_ovr = 1'b0; m_rxbuf = 8'h00;
        b_clk = 16 * (16'h0516 + 1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset_txd", {7'b0, txd}, 8'h01);
        checkOutput("reset_tbr", {7'b0, tbr}, 8'h01);
        checkOutput("reset_rda", {7'b0, rda}, 8'h00);
        busRead(2'b01, rd);
        checkOutput("reset_status", rd, 8'h01);
        busRead(2'b10, rd);
        checkOutput("reset_dbl", rd, 8'h16);
        busRead(2'b11, rd);
        checkOutput("reset_dbh", rd, 8'h05);

        // Divisor 2: 48 clocks per bit
        setDivisor(16'h0002);

        // Single TX frame: tbr low for exactly one cycle, start bit exactly 48 clocks wide
        applyStimulus(2'b00, 8'h41);
        txq.push_back(8'h41);
        @(negedge clk);
        checkOutput("tbr_low", {7'b0, tbr}, 8'h00);
        @(negedge clk);
        checkOutput("tbr_back", {7'b0, tbr}, 8'h01);
        seen = 1'b0;
        for (int i = 0; i < 4 * b_clk; i++) begin
            if (txd == 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) reportTimeout("start_edge");
        else begin
            cnt = 0;
            while (txd == 1'b0 && cnt < 200) begin
                cnt++;
                @(negedge clk);
            end
            checkOutput("start_width", 8'(cnt), 8'd48);
        end
        waitTxDone();

        // Back-to-back frames; a third write while the buffer is full is dropped
        applyStimulus(2'b00, 8'h41);
        txq.push_back(8'h41);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tbr == 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportTimeout("tbr_return");
        applyStimulus(2'b00, 8'h5A);
        txq.push_back(8'h5A);
        applyStimulus(2'b00, 8'h99);
        @(negedge clk);
        checkOutput("tbr_full", {7'b0, tbr}, 8'h00);
        waitTxDone();

        // RX frame 8'hA5, read back, rda clears
        sendRxFrame(8'hA5, 1'b1);
        @(negedge clk);
        checkOutput("rda_set", {7'b0, rda}, 8'h01);
        busRead(2'b00, rd);
        checkOutput("rx_a5", rd, 8'hA5);
        m_rda = 1'b0;
        @(negedge clk);
        checkOutput("rda_clear", {7'b0, rda}, 8'h00);

        // Short low glitch on rxd is rejected
        @(posedge clk); #1;
        rxd = 1'b0;
        repeat (b_clk / 4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (2 * b_clk) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch_rda", {7'b0, rda}, 8'h00);

        // Framing error discards the byte
        sendRxFrame(8'h3C, 1'b0);
        @(negedge clk);
        checkOutput("framing_rda", {7'b0, rda}, 8'h00);

        // Two frames without reading: overrun behaviour and buffer overwrite
        sendRxFrame(8'h11, 1'b1);
        sendRxFrame(8'h22, 1'b1);
        busRead(2'b01, rd);
`ifdef SPART_OVERRUN_EN
        checkOutput("status_ovr", rd, 8'h07);
`else
        checkOutput("status_ovr", rd, 8'h03);
`endif
        m_ovr = 1'b0;
        busRead(2'b01, rd);
        checkOutput("status_after", rd, 8'h03);
        busRead(2'b00, rd);
        checkOutput("rx_second", rd, 8'h22);
        m_rda = 1'b0;

        // Randomized rounds at assorted divisors
        for (int r = 0; r < 6; r++) begin
            div = 16'($urandom_range(1, 3));
            setDivisor(div);
            byte_v = 8'($urandom);
            applyStimulus(2'b00, byte_v);
            txq.push_back(byte_v);
            waitTxDone();
            for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
                byte_v = 8'($urandom);
                sendRxFrame(byte_v, $urandom_range(0, 4) != 0);
            end
            readStatus();
            if ($urandom_range(0, 1) == 1) readRx();
        end

        repeat (10) @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
